// File: rtl/adc_frame_serializer_pkg.sv
// Shared definitions for the ADC frame serializer: FSM state encoding,
// default frame constants and SPI mode bits.
package adc_frame_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  localparam int DEF_BITS_RESOLUTION = 24;
  localparam int DEF_SCLK_DIV        = 4;
  localparam int DEF_CS_SETUP_CYC    = 2;
  localparam int DEF_CS_HOLD_CYC     = 2;
  localparam int DEF_PARITY_EN       = 0;

  // Mode 0: SCLK idles low, data sampled on the rising edge.
  localparam logic SPI_CPOL = 1'b0;
  localparam logic SPI_CPHA = 1'b0;

endpackage

// File: rtl/adc_frame_serializer_sclk_phase_gen.sv
// SCLK phase generator: half-period and bit counters for the SHIFT state.
// Outputs describe what the next clock edge will do to SCLK.
module sclk_phase_gen #(
  parameter int NBITS    = 24,
  parameter int SCLK_DIV = 4
) (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic Srst_i,
  output logic Low_Start_o,
  output logic Rise_o,
  output logic Fall_o,
  output logic Last_Bit_o
);

  localparam int DW = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int BW = (NBITS > 1) ? $clog2(NBITS) : 1;

  logic [DW-1:0] div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          phase_q, phase_d;
  logic          half_end_s;

  assign half_end_s  = (div_q == DW'(SCLK_DIV - 1));
  assign Rise_o      = half_end_s & ~phase_q;
  assign Fall_o      = half_end_s & phase_q;
  assign Last_Bit_o  = (bit_q == BW'(NBITS - 1));
  assign Low_Start_o = Fall_o & ~Last_Bit_o;

  always_comb begin
    div_d   = div_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    if (Srst_i) begin
      div_d   = '0;
      bit_d   = '0;
      phase_d = 1'b0;
    end else if (half_end_s) begin
      div_d   = '0;
      phase_d = ~phase_q;
      bit_d   = phase_q ? bit_q + BW'(1) : bit_q;
    end else begin
      div_d   = div_q + DW'(1);
    end
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      div_q   <= '0;
      bit_q   <= '0;
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      bit_q   <= bit_d;
      phase_q <= phase_d;
    end
  end

endmodule

// File: rtl/adc_frame_serializer.sv
// Serial ADC frame emitter: latches a parallel sample on strobe and shifts it
// out MSB-first as an nCS/SCLK/SDO frame, with optional even parity.
module adc_frame_serializer
  import adc_frame_serializer_pkg::*;
#(
  parameter int BITS_RESOLUTION = DEF_BITS_RESOLUTION,
  parameter int SCLK_DIV        = DEF_SCLK_DIV,
  parameter int CS_SETUP_CYC    = DEF_CS_SETUP_CYC,
  parameter int CS_HOLD_CYC     = DEF_CS_HOLD_CYC,
  parameter int PARITY_EN       = DEF_PARITY_EN
) (
  input  logic                       Clk_i,
  input  logic                       Reset_i,
  input  logic [BITS_RESOLUTION-1:0] Val_i,
  input  logic                       Strobe_i,
  input  logic                       Clr_Ovr_i,
  output logic                       nCS_o,
  output logic                       SCLK_o,
  output logic                       SDO_o,
  output logic                       Busy_o,
  output logic                       Done_o,
  output logic                       Overrun_o
);

  localparam int N       = BITS_RESOLUTION + PARITY_EN;
  localparam int CNT_MAX = (CS_SETUP_CYC > CS_HOLD_CYC) ? CS_SETUP_CYC : CS_HOLD_CYC;
  localparam int CW      = $clog2(CNT_MAX + 1);

  state_e              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [N-1:0]        sh_q, sh_d;
  logic                ncs_q, ncs_d, busy_q, busy_d;
  logic                sclk_q, sclk_d, sdo_q, sdo_d;
  logic                done_q, done_d, ovr_q, ovr_d;
  logic [BITS_RESOLUTION:0] load_s;
  logic                low_start_s, rise_s, fall_s, last_bit_s;

  // Parity sits below the LSB; the part-select drops it when disabled.
  assign load_s = {Val_i, ^Val_i};

  sclk_phase_gen #(
    .NBITS    (N),
    .SCLK_DIV (SCLK_DIV)
  ) u_phase (
    .Clk_i       (Clk_i),
    .Reset_i     (Reset_i),
    .Srst_i      (state_q != ST_SHIFT),
    .Low_Start_o (low_start_s),
    .Rise_o      (rise_s),
    .Fall_o      (fall_s),
    .Last_Bit_o  (last_bit_s)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    sdo_d   = sdo_q;
    sclk_d  = SPI_CPOL;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        sdo_d = 1'b0;
        if (Strobe_i) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          sh_d    = load_s[BITS_RESOLUTION -: N];
          sdo_d   = Val_i[BITS_RESOLUTION-1];
        end
      end
      ST_SETUP: begin
        if (cnt_q == CW'(CS_SETUP_CYC - 1)) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      ST_SHIFT: begin
        if (rise_s) begin
          sclk_d = 1'b1;
        end else if (fall_s) begin
          sclk_d = 1'b0;
        end else begin
          sclk_d = sclk_q;
        end
        if (low_start_s) begin
          sh_d  = {sh_q[N-2:0], 1'b0};
          sdo_d = sh_q[N-2];
        end
        if (fall_s && last_bit_s) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end
      end
      ST_HOLD: begin
        if (cnt_q == CW'(CS_HOLD_CYC - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          sdo_d   = 1'b0;
        end else begin
          cnt_d   = cnt_q + CW'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        sdo_d   = 1'b0;
      end
    endcase

    ncs_d  = (state_d == ST_IDLE);
    busy_d = (state_d != ST_IDLE);
    // An overrun set takes priority over a coincident clear.
    if (Strobe_i && (state_q != ST_IDLE)) begin
      ovr_d = 1'b1;
    end else if (Clr_Ovr_i) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
  end

  always_ff @(posedge Clk_i or posedge Reset_i) begin
    if (Reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      sclk_q  <= SPI_CPOL;
      sdo_q   <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      ncs_q   <= ncs_d;
      busy_q  <= busy_d;
      sclk_q  <= sclk_d;
      sdo_q   <= sdo_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  assign nCS_o     = ncs_q;
  assign SCLK_o    = sclk_q;
  assign SDO_o     = sdo_q;
  assign Busy_o    = busy_q;
  assign Done_o    = done_q;
  assign Overrun_o = ovr_q;

endmodule

// File: tb/tb_adc_frame_serializer.sv
// Self-checking bench: three serializer configurations (defaults, parity,
// fastest timing) checked against a frame-level model.
module tb_adc_frame_serializer;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]  rst, strobe, clr;
  logic [23:0] val [3];
  logic [2:0]  ncs, sclk, sdo, busy, done, ovr;

  int checks   = 0;
  int failures = 0;

  adc_frame_serializer u_def (
    .Clk_i(clk), .Reset_i(rst[0]), .Val_i(val[0]), .Strobe_i(strobe[0]), .Clr_Ovr_i(clr[0]),
    .nCS_o(ncs[0]), .SCLK_o(sclk[0]), .SDO_o(sdo[0]), .Busy_o(busy[0]), .Done_o(done[0]),
    .Overrun_o(ovr[0]));

  adc_frame_serializer #(.PARITY_EN(1)) u_par (
    .Clk_i(clk), .Reset_i(rst[1]), .Val_i(val[1]), .Strobe_i(strobe[1]), .Clr_Ovr_i(clr[1]),
    .nCS_o(ncs[1]), .SCLK_o(sclk[1]), .SDO_o(sdo[1]), .Busy_o(busy[1]), .Done_o(done[1]),
    .Overrun_o(ovr[1]));

  adc_frame_serializer #(.SCLK_DIV(1), .CS_SETUP_CYC(1), .CS_HOLD_CYC(1)) u_fast (
    .Clk_i(clk), .Reset_i(rst[2]), .Val_i(val[2]), .Strobe_i(strobe[2]), .Clr_Ovr_i(clr[2]),
    .nCS_o(ncs[2]), .SCLK_o(sclk[2]), .SDO_o(sdo[2]), .Busy_o(busy[2]), .Done_o(done[2]),
    .Overrun_o(ovr[2]));

  typedef struct {
    int          d;
    logic [23:0] v;
    int          exp_n;
    int          exp_low;
    logic        exp_last;
  } vec_t;

  vec_t tbl [5];

  // Frame-level model of each configuration.
  function automatic int pe_of(input int d);  return (d == 1) ? 1 : 0; endfunction
  function automatic int div_of(input int d); return (d == 2) ? 1 : 4; endfunction
  function automatic int su_of(input int d);  return (d == 2) ? 1 : 2; endfunction
  function automatic int ho_of(input int d);  return (d == 2) ? 1 : 2; endfunction
  function automatic int model_n(input int d); return 24 + pe_of(d); endfunction
  function automatic int model_low(input int d);
    return su_of(d) + 2 * div_of(d) * model_n(d) + ho_of(d);
  endfunction
  function automatic logic [31:0] model_word(input int d, input logic [23:0] v);
    int ones = 0;
    logic [31:0] w = {8'h00, v};
    for (int i = 0; i < 24; i++) ones += int'(v[i]);
    if (pe_of(d) == 1) w = {w[30:0], (ones % 2 == 1)};
    return w;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Called on a negedge; leaves the caller on the negedge after the strobe edge.
  task automatic do_strobe(input int d, input logic [23:0] v);
    val[d]    = v;
    strobe[d] = 1'b1;
    @(negedge clk);
    strobe[d] = 1'b0;
  endtask

  task automatic capture(input int d, output logic [31:0] word, output int nbits,
                         output int low, output int first_rise, output int period,
                         output int done_cnt, output int busy_bad, output logic done_end);
    int   idx = 0;
    int   second = -1;
    logic prev = 1'b0;
    word = '0; nbits = 0; first_rise = -1; done_cnt = 0; busy_bad = 0;
    while (ncs[d] === 1'b0 && idx < 400) begin
      if (sclk[d] === 1'b1 && prev === 1'b0) begin
        word = {word[30:0], sdo[d]};
        nbits++;
        if (first_rise < 0) first_rise = idx;
        else if (second < 0) second = idx;
      end
      prev = sclk[d];
      if (done[d] === 1'b1) done_cnt++;
      if (busy[d] !== ~ncs[d]) busy_bad++;
      idx++;
      @(negedge clk);
    end
    low      = idx;
    period   = second - first_rise;
    done_end = done[d];
    if (busy[d] !== ~ncs[d]) busy_bad++;
  endtask

  task automatic check_frame(input string tag, input int d, input logic [23:0] v,
                             input int exp_n, input int exp_low, output logic [31:0] w);
    int nb, low, fr, per, dc, bb;
    logic de;
    capture(d, w, nb, low, fr, per, dc, bb, de);
    chk({tag, "_word"},   w, model_word(d, v));
    chk({tag, "_nbits"},  nb, exp_n);
    chk({tag, "_ncs_low"}, low, exp_low);
    chk({tag, "_first_rise"}, fr, su_of(d) + div_of(d));
    chk({tag, "_sclk_period"}, per, 2 * div_of(d));
    chk({tag, "_early_done"}, dc, 0);
    chk({tag, "_done_end"}, de, 1'b1);
    chk({tag, "_busy_ncs"}, bb, 0);
  endtask

  task automatic check_idle(input string tag, input int d);
    chk({tag, "_ncs"},  ncs[d],  1'b1);
    chk({tag, "_sclk"}, sclk[d], 1'b0);
    chk({tag, "_sdo"},  sdo[d],  1'b0);
    chk({tag, "_busy"}, busy[d], 1'b0);
    chk({tag, "_done"}, done[d], 1'b0);
    chk({tag, "_ovr"},  ovr[d],  1'b0);
  endtask

  initial begin
    logic [31:0] w;
    logic [23:0] rv;
    int          rd, dseen;

    tbl[0] = '{0, 24'hA5A5A5, 24, 196, 1'b1};
    tbl[1] = '{1, 24'h000001, 25, 204, 1'b1};
    tbl[2] = '{1, 24'h000003, 25, 204, 1'b0};
    tbl[3] = '{2, 24'hFFFFFF, 24, 50,  1'b1};
    tbl[4] = '{0, 24'h800001, 24, 196, 1'b1};

    rst = 3'b111; strobe = 3'b000; clr = 3'b000;
    for (int i = 0; i < 3; i++) val[i] = 24'h000000;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle($sformatf("reset_held%0d", i), i);
    rst = 3'b000;
    @(negedge clk);
    for (int i = 0; i < 3; i++) check_idle($sformatf("reset_rel%0d", i), i);

    // Directed frame table
    for (int i = 0; i < 5; i++) begin
      do_strobe(tbl[i].d, tbl[i].v);
      check_frame($sformatf("tbl%0d", i), tbl[i].d, tbl[i].v, tbl[i].exp_n, tbl[i].exp_low, w);
      if (tbl[i].exp_n == 25) chk($sformatf("tbl%0d_parity", i), w[0], tbl[i].exp_last);
      chk($sformatf("tbl%0d_ovr", i), ovr[tbl[i].d], 1'b0);
      repeat (2) @(negedge clk);
    end

    // Back-to-back frames: second strobe lands in the Done_o cycle.
    do_strobe(0, 24'h5A5A5A);
    check_frame("b2b_first", 0, 24'h5A5A5A, 24, 196, w);
    do_strobe(0, 24'h123456);
    chk("b2b_ncs_gap", ncs[0], 1'b0);
    check_frame("b2b_second", 0, 24'h123456, 24, 196, w);
    chk("b2b_second_val", w, 32'h00123456);
    @(negedge clk);

    // Overrun: strobe mid-frame, clear, then coincident clear and strobe.
    do_strobe(0, 24'hC3C3C3);
    fork
      check_frame("ovr_frame", 0, 24'hC3C3C3, 24, 196, w);
      begin
        repeat (50) @(negedge clk);
        chk("ovr_before", ovr[0], 1'b0);
        val[0] = 24'h0F0F0F; strobe[0] = 1'b1;
        @(negedge clk);
        strobe[0] = 1'b0;
        chk("ovr_set", ovr[0], 1'b1);
        repeat (10) @(negedge clk);
        clr[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0;
        chk("ovr_clear", ovr[0], 1'b0);
        repeat (5) @(negedge clk);
        clr[0] = 1'b1; strobe[0] = 1'b1;
        @(negedge clk);
        clr[0] = 1'b0; strobe[0] = 1'b0;
        chk("ovr_set_wins", ovr[0], 1'b1);
      end
    join
    chk("ovr_sticky", ovr[0], 1'b1);
    clr[0] = 1'b1;
    @(negedge clk);
    clr[0] = 1'b0;
    chk("ovr_final_clear", ovr[0], 1'b0);

    // Asynchronous reset during bit 10.
    do_strobe(0, 24'hFFFFFF);
    repeat (84) @(negedge clk);
    chk("rst_pre_sdo", sdo[0], 1'b1);
    rst[0] = 1'b1;
    #1;
    chk("rst_async_ncs",  ncs[0],  1'b1);
    chk("rst_async_sclk", sclk[0], 1'b0);
    chk("rst_async_sdo",  sdo[0],  1'b0);
    chk("rst_async_busy", busy[0], 1'b0);
    dseen = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) dseen++;
    end
    rst[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (done[0] === 1'b1) dseen++;
    end
    chk("rst_no_done", dseen, 0);
    do_strobe(0, 24'h3C96E1);
    check_frame("rst_after", 0, 24'h3C96E1, 24, 196, w);

    // Randomized frames against the model.
    for (int i = 0; i < 8; i++) begin
      rd = $urandom_range(2, 0);
      rv = 24'($urandom);
      repeat ($urandom_range(3, 1)) @(negedge clk);
      do_strobe(rd, rv);
      check_frame($sformatf("rnd%0d_d%0d", i, rd), rd, rv, model_n(rd), model_low(rd), w);
      chk($sformatf("rnd%0d_ovr", i), ovr[rd], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
